// File: rtl/filter_channel_scheduler.sv
// Sequences one shared two-pass filter across CHANNELS voices per frame and keeps each voice's {z1,z2}.
// Optional FILTER_SCHED_CLEAR_EN adds a clear input that zeroes all channel state from IDLE.
module filter_channel_scheduler #(
  parameter int CHANNELS = 8,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_start,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [CW-1:0] ch_index,
  output logic          sample_req,
  input  logic          sample_valid,
  input  logic [15:0]   sample_in,
  output logic          filt_pass,
  output logic [15:0]   filt_in,
  output logic [63:0]   filt_data,
  input  logic [63:0]   filt_odata,
  input  logic [15:0]   filt_out,
  output logic          out_valid,
  output logic [15:0]   sample_out,
  output logic [CW-1:0] out_ch
`ifdef FILTER_SCHED_CLEAR_EN
  ,
  input  logic          clear
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PASS0,
    S_PASS1,
    S_WB
`ifdef FILTER_SCHED_CLEAR_EN
    ,
    S_CLEAR
`endif
  } state_t;

  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   sample_q, sample_d;
  logic          pass_q, pass_d;
  logic [15:0]   sample_out_q, sample_out_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic          wr_en;
  logic [63:0]   wr_data;
  logic [63:0]   state_rd [CHANNELS];

  // One register per channel; only the entry addressed by ch_q is ever written.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_state
    logic [63:0] entry_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        entry_q <= '0;
      end else if (wr_en && (ch_q == CW'(gi))) begin
        entry_q <= wr_data;
      end
    end

    assign state_rd[gi] = entry_q;
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    overrun_d    = overrun_q;
    sample_d     = sample_q;
    pass_d       = pass_q;
    sample_out_d = sample_out_q;
    out_ch_d     = out_ch_q;
    wr_en        = 1'b0;
    wr_data      = filt_odata;
    busy         = (state_q != S_IDLE);
    sample_req   = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    filt_data    = state_rd[ch_q];

    unique case (state_q)
      S_IDLE: begin
`ifdef FILTER_SCHED_CLEAR_EN
        if (clear) begin
          state_d = S_CLEAR;
          ch_d    = '0;
          if (frame_start) overrun_d = 1'b1;
        end else
`endif
        if (frame_start) begin
          state_d = S_REQ;
          ch_d    = '0;
        end
      end
      S_REQ: begin
        sample_req = 1'b1;
        if (sample_valid) begin
          sample_d = sample_in;
          pass_d   = 1'b0;
          state_d  = S_PASS0;
        end
      end
      S_PASS0: begin
        pass_d  = 1'b1;
        state_d = S_PASS1;
      end
      S_PASS1: begin
        // Second pass runs on the intermediate state the filter just registered.
        filt_data    = filt_odata;
        sample_out_d = filt_out;
        out_ch_d     = ch_q;
        state_d      = S_WB;
      end
      S_WB: begin
        wr_en     = 1'b1;
        out_valid = 1'b1;
        if (ch_q == LAST_CH) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_REQ;
        end
      end
`ifdef FILTER_SCHED_CLEAR_EN
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_data = '0;
        if (ch_q == LAST_CH) begin
          state_d = S_IDLE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (frame_start && (state_q != S_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      overrun_q    <= 1'b0;
      sample_q     <= '0;
      pass_q       <= 1'b0;
      sample_out_q <= '0;
      out_ch_q     <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      overrun_q    <= overrun_d;
      sample_q     <= sample_d;
      pass_q       <= pass_d;
      sample_out_q <= sample_out_d;
      out_ch_q     <= out_ch_d;
    end
  end

  assign overrun    = overrun_q;
  assign ch_index   = ch_q;
  assign filt_pass  = pass_q;
  assign filt_in    = sample_q;
  assign sample_out = sample_out_q;
  assign out_ch     = out_ch_q;

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Randomized bench for filter_channel_scheduler (CHANNELS=4) with a toy two-pass filter and a per-channel reference model.
module tb_filter_channel_scheduler;

  localparam int CH = 4;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          busy, done, overrun, sample_req, filt_pass, out_valid;
  logic [CW-1:0] ch_index, out_ch;
  logic          sample_valid;
  logic [15:0]   sample_in, filt_in, sample_out, filt_out;
  logic [63:0]   filt_data;
  logic [63:0]   filt_odata = '0;
`ifdef FILTER_SCHED_CLEAR_EN
  logic          clear;
`endif

  int passed = 0;
  int total  = 0;

  logic [63:0] ref_st     [CH];
  logic [63:0] exp_p0     [CH];
  logic [15:0] exp_out    [CH];
  logic [15:0] xs_cur     [CH];
  logic [63:0] pass0_data [CH];
  logic [63:0] wb_odata   [CH];
  int          req_cnt    [CH];
  logic [15:0] out_val_a  [16];
  int          out_ch_a   [16];
  int          out_cyc_a  [16];
  int          n_out, done_cyc, done_cnt, busy_cyc;
  bit          timeout;

  filter_channel_scheduler #(.CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .busy(busy), .done(done), .overrun(overrun), .ch_index(ch_index),
    .sample_req(sample_req), .sample_valid(sample_valid), .sample_in(sample_in),
    .filt_pass(filt_pass), .filt_in(filt_in), .filt_data(filt_data),
    .filt_odata(filt_odata), .filt_out(filt_out),
    .out_valid(out_valid), .sample_out(sample_out), .out_ch(out_ch)
`ifdef FILTER_SCHED_CLEAR_EN
    , .clear(clear)
`endif
  );

  always #5 clock = ~clock;

  // Toy filter: pass 0 -> g0, pass 1 -> g1 into a register; OUT = h on pass 1.
  function automatic logic [63:0] g0(input logic [63:0] d, input logic [15:0] x);
    return {d[63:32] + {{16{x[15]}}, x}, d[31:0] ^ {x, 16'h0080}};
  endfunction
  function automatic logic [63:0] g1(input logic [63:0] d, input logic [15:0] x);
    return {d[31:0] ^ d[63:32], d[63:32] - {16'h0000, x}};
  endfunction
  function automatic logic [15:0] h(input logic [63:0] d, input logic [15:0] x);
    return d[47:32] + x;
  endfunction

  always @(posedge clock) filt_odata <= filt_pass ? g1(filt_data, filt_in) : g0(filt_data, filt_in);
  assign filt_out = filt_pass ? h(filt_data, filt_in) : ~filt_in;

  task automatic randomize_inputs();
    for (int c = 0; c < CH; c++) xs_cur[c] = 16'($urandom);
  endtask

  // Reference: each channel sees x, state s; out = h(g0(s,x),x), new s = g1(g0(s,x),x).
  task automatic model_sweep();
    logic [63:0] s1;
    for (int c = 0; c < CH; c++) begin
      exp_p0[c]  = ref_st[c];
      s1         = g0(ref_st[c], xs_cur[c]);
      exp_out[c] = h(s1, xs_cur[c]);
      ref_st[c]  = g1(s1, xs_cur[c]);
    end
  endtask

  // Drives one sweep and records what the DUT did; cycle 1 is the first REQ cycle.
  task automatic sweep(input int wait_ch, input int wait_n, input int fs_mid, input bit fs_done);
    int  cyc;
    int  waited;
    bit  in_p0;
    n_out = 0; done_cyc = -1; done_cnt = 0; busy_cyc = 0; timeout = 0;
    waited = 0; in_p0 = 0;
    for (int c = 0; c < CH; c++) req_cnt[c] = 0;
    @(negedge clock); frame_start = 1'b1;
    @(negedge clock); frame_start = 1'b0;
    for (cyc = 1; cyc < 300; cyc++) begin
      frame_start = 1'b0;
      if (busy !== 1'b1) break;
      busy_cyc++;
      if (in_p0) pass0_data[ch_index] = filt_data;
      in_p0 = 0;
      sample_valid = 1'b0;
      if (sample_req === 1'b1) begin
        req_cnt[ch_index]++;
        if (int'(ch_index) == wait_ch && waited < wait_n) begin
          waited++;
        end else begin
          sample_valid = 1'b1;
          sample_in    = xs_cur[ch_index];
          in_p0        = 1;
        end
      end
      if (out_valid === 1'b1 && n_out < 16) begin
        out_ch_a[n_out]  = int'(out_ch);
        out_val_a[n_out] = sample_out;
        out_cyc_a[n_out] = cyc;
        wb_odata[out_ch] = filt_odata;
        n_out++;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        done_cnt++;
        if (fs_done) frame_start = 1'b1;
      end
      if (cyc == fs_mid) frame_start = 1'b1;
      @(negedge clock);
    end
    if (cyc >= 300) timeout = 1;
    sample_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++;
    if ({busy, done, overrun, sample_req, out_valid, filt_pass} !== 6'b0) begin
      $display("FAIL reset_flags got=%b want=000000", {busy, done, overrun, sample_req, out_valid, filt_pass});
    end else passed++;
    total++;
    if ({ch_index, out_ch, sample_out, filt_in} !== '0) begin
      $display("FAIL reset_regs got ch=%0d och=%0d so=%h fi=%h want all 0", ch_index, out_ch, sample_out, filt_in);
    end else passed++;
    total++;
    if (filt_data !== 64'h0) begin
      $display("FAIL reset_filt_data got=%h want=0", filt_data);
    end else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (busy !== 1'b0 || sample_req !== 1'b0) begin
      $display("FAIL idle_after_reset got busy=%b req=%b want 0 0", busy, sample_req);
    end else passed++;
  endtask

  task automatic test_single_sweep();
    randomize_inputs();
    model_sweep();
    sweep(-1, 0, -1, 0);
    total++;
    if (timeout || n_out != CH) begin
      $display("FAIL single_count got=%0d timeout=%0b want=%0d", n_out, timeout, CH);
    end else passed++;
    for (int i = 0; i < CH; i++) begin
      total++;
      if (out_cyc_a[i] != 4 * (i + 1) || out_ch_a[i] != i) begin
        $display("FAIL single_timing[%0d] got cyc=%0d ch=%0d want cyc=%0d ch=%0d", i, out_cyc_a[i], out_ch_a[i], 4 * (i + 1), i);
      end else passed++;
      total++;
      if (out_val_a[i] !== exp_out[i]) begin
        $display("FAIL single_out[%0d] got=%h want=%h", i, out_val_a[i], exp_out[i]);
      end else passed++;
      total++;
      if (pass0_data[i] !== exp_p0[i]) begin
        $display("FAIL single_p0[%0d] got=%h want=%h", i, pass0_data[i], exp_p0[i]);
      end else passed++;
    end
    total++;
    if (done_cyc != 4 * CH || done_cnt != 1 || busy_cyc != 4 * CH) begin
      $display("FAIL single_done got done_cyc=%0d n=%0d busy=%0d want %0d 1 %0d", done_cyc, done_cnt, busy_cyc, 4 * CH, 4 * CH);
    end else passed++;
    total++;
    if (overrun !== 1'b0) begin
      $display("FAIL single_overrun got=%b want=0", overrun);
    end else passed++;
    $display("sweep single: done at cycle %0d, %0d outputs", done_cyc, n_out);
  endtask

  task automatic test_backpressure();
    randomize_inputs();
    model_sweep();
    sweep(2, 5, -1, 0);
    total++;
    if (req_cnt[2] != 6) begin
      $display("FAIL bp_req_ch2 got=%0d want=6", req_cnt[2]);
    end else passed++;
    total++;
    if (timeout || busy_cyc != 4 * CH + 5 || done_cyc != 4 * CH + 5) begin
      $display("FAIL bp_length got busy=%0d done=%0d want %0d", busy_cyc, done_cyc, 4 * CH + 5);
    end else passed++;
    for (int i = 0; i < CH; i++) begin
      total++;
      if (out_ch_a[i] != i || out_val_a[i] !== exp_out[i]) begin
        $display("FAIL bp_out[%0d] got ch=%0d v=%h want ch=%0d v=%h", i, out_ch_a[i], out_val_a[i], i, exp_out[i]);
      end else passed++;
    end
    $display("sweep backpressure: %0d cycles", busy_cyc);
  endtask

  task automatic test_persistence();
    logic [63:0] wb1;
    randomize_inputs();
    xs_cur[1] = 16'h4000;
    model_sweep();
    sweep(-1, 0, -1, 0);
    wb1 = wb_odata[1];
    total++;
    if (wb1 !== ref_st[1]) begin
      $display("FAIL persist_wb1 got=%h want=%h", wb1, ref_st[1]);
    end else passed++;
    randomize_inputs();
    xs_cur[1] = 16'h4000;
    model_sweep();
    sweep(-1, 0, -1, 0);
    total++;
    if (pass0_data[1] !== wb1) begin
      $display("FAIL persist_ch1 got=%h want=%h", pass0_data[1], wb1);
    end else passed++;
    for (int i = 0; i < CH; i++) begin
      total++;
      if (pass0_data[i] !== exp_p0[i] || out_val_a[i] !== exp_out[i]) begin
        $display("FAIL persist_ch[%0d] got p0=%h o=%h want p0=%h o=%h", i, pass0_data[i], out_val_a[i], exp_p0[i], exp_out[i]);
      end else passed++;
    end
    $display("sweep persistence: ch1 state %h", wb1);
  endtask

  task automatic test_overrun();
    bit extra;
    randomize_inputs();
    model_sweep();
    sweep(-1, 0, 6, 1);
    total++;
    if (overrun !== 1'b1) begin
      $display("FAIL overrun_set got=%b want=1", overrun);
    end else passed++;
    total++;
    if (timeout || n_out != CH || done_cnt != 1) begin
      $display("FAIL overrun_sweep got outs=%0d done=%0d want %0d 1", n_out, done_cnt, CH);
    end else passed++;
    for (int i = 0; i < CH; i++) begin
      total++;
      if (out_val_a[i] !== exp_out[i]) begin
        $display("FAIL overrun_out[%0d] got=%h want=%h", i, out_val_a[i], exp_out[i]);
      end else passed++;
    end
    extra = 0;
    repeat (6) begin
      if (busy !== 1'b0) extra = 1;
      @(negedge clock);
    end
    total++;
    if (extra || overrun !== 1'b1) begin
      $display("FAIL overrun_no_restart got extra=%0b ovr=%b want 0 1", extra, overrun);
    end else passed++;
    $display("sweep overrun: overrun=%b", overrun);
  endtask

  task automatic test_async_reset();
    @(negedge clock); frame_start = 1'b1;
    @(negedge clock); frame_start = 1'b0;
    for (int cyc = 1; cyc < 11; cyc++) begin
      sample_valid = 1'b1;
      sample_in    = 16'($urandom);
      @(negedge clock);
    end
    total++;
    if (filt_pass !== 1'b1 || ch_index !== 2'd2) begin
      $display("FAIL areset_pos got pass=%b ch=%0d want 1 2", filt_pass, ch_index);
    end else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, overrun, sample_req, out_valid, filt_pass} !== 6'b0) begin
      $display("FAIL areset_flags got=%b want=000000", {busy, done, overrun, sample_req, out_valid, filt_pass});
    end else passed++;
    total++;
    if ({ch_index, out_ch, sample_out, filt_in} !== '0 || filt_data !== 64'h0) begin
      $display("FAIL areset_regs got ch=%0d och=%0d so=%h fi=%h fd=%h want 0", ch_index, out_ch, sample_out, filt_in, filt_data);
    end else passed++;
    sample_valid = 1'b0;
    @(negedge clock); reset = 1'b0;
    for (int c = 0; c < CH; c++) ref_st[c] = '0;
    randomize_inputs();
    model_sweep();
    sweep(-1, 0, -1, 0);
    for (int i = 0; i < CH; i++) begin
      total++;
      if (pass0_data[i] !== 64'h0 || out_val_a[i] !== exp_out[i]) begin
        $display("FAIL areset_after[%0d] got p0=%h o=%h want p0=0 o=%h", i, pass0_data[i], out_val_a[i], exp_out[i]);
      end else passed++;
    end
    $display("sweep after async reset: %0d outputs", n_out);
  endtask

`ifdef FILTER_SCHED_CLEAR_EN
  task automatic test_clear();
    int bcyc;
    @(negedge clock); clear = 1'b1; frame_start = 1'b1;
    @(negedge clock); clear = 1'b0; frame_start = 1'b0;
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 100) begin
      bcyc++;
      @(negedge clock);
    end
    total++;
    if (bcyc != CH) begin
      $display("FAIL clear_busy got=%0d want=%0d", bcyc, CH);
    end else passed++;
    total++;
    if (overrun !== 1'b1) begin
      $display("FAIL clear_overrun got=%b want=1", overrun);
    end else passed++;
    for (int c = 0; c < CH; c++) ref_st[c] = '0;
    randomize_inputs();
    model_sweep();
    sweep(-1, 0, -1, 0);
    for (int i = 0; i < CH; i++) begin
      total++;
      if (pass0_data[i] !== 64'h0 || out_val_a[i] !== exp_out[i]) begin
        $display("FAIL clear_after[%0d] got p0=%h o=%h want p0=0 o=%h", i, pass0_data[i], out_val_a[i], exp_out[i]);
      end else passed++;
    end
    $display("sweep after clear: busy %0d cycles", bcyc);
  endtask
`endif

  initial begin
    reset        = 1'b1;
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
`ifdef FILTER_SCHED_CLEAR_EN
    clear        = 1'b0;
`endif
    for (int c = 0; c < CH; c++) ref_st[c] = '0;
    test_reset();
    test_single_sweep();
    test_backpressure();
    test_persistence();
    test_overrun();
    test_async_reset();
`ifdef FILTER_SCHED_CLEAR_EN
    test_clear();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
